// File: rtl/snowball_cache_burst.sv
// snowball_cache_burst: direct-mapped write-through data cache with wrapped burst refill and flush
// Ports: CPU_CLK/RST clock and synchronous active-high reset; cache_precycle_* CPU request,
// cache_datao store data, cache_inhibit uncached access, cache_flush invalidate-all pulse,
// cache_datai load data, cache_busy stall; mem_* memory-controller request, ack and read beats.
// Option: define SNOWBALL_CACHE_CRITWORD_EN for critical-word-first refill with early release.
module snowball_cache_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W = 8,
  parameter int LINE_W = 1
) (
  input  logic              CPU_CLK,
  input  logic              RST,
  input  logic              cache_precycle_enable,
  input  logic [ADDR_W-1:0] cache_precycle_addr,
  input  logic              cache_precycle_we,
  input  logic [DATA_W-1:0] cache_datao,
  input  logic              cache_inhibit,
  input  logic              cache_flush,
  output logic [DATA_W-1:0] cache_datai,
  output logic              cache_busy,
  output logic              mem_do_act,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataintomem,
  input  logic              mem_ack,
  input  logic              mem_data_vld,
  input  logic [DATA_W-1:0] mem_datafrommem
);
  localparam int AW = IDX_W + LINE_W;
  localparam int TW = ADDR_W - AW;
  localparam int OW = LINE_W > 0 ? LINE_W : 1;
  localparam int NS = 1 << IDX_W;
  localparam logic [OW-1:0] OMSK = OW'((1 << LINE_W) - 1);
  localparam logic [ADDR_W-1:0] AMSK = ADDR_W'((1 << LINE_W) - 1);
`ifdef SNOWBALL_CACHE_CRITWORD_EN
  localparam bit CW = 1'b1;
`else
  localparam bit CW = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, RD_REQ = 3'd2, RD_FILL = 3'd3, WR_REQ = 3'd4, DONE = 3'd5;

  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, p_addr_q, p_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, p_wdata_q, p_wdata_d, datai_q, datai_d, rdata_q, arr_wd;
  logic we_q, we_d, inh_q, inh_d, p_we_q, p_we_d, p_inh_q, p_inh_d;
  logic pend_q, pend_d, cap_q, cap_d, flush_pend_q, flush_pend_d;
  logic [OW-1:0] k_q, k_d, req_off, first_off, woff;
  logic [NS-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_mem [0:(1<<AW)-1];
  logic [TW-1:0] tag_mem [0:NS-1];
  logic [IDX_W-1:0] set;
  logic [TW-1:0] tag;
  logic [AW-1:0] raddr, arr_wa, fill_a;
  logic hit, rd_hit, last, acc, clr, arr_we, tag_we;

  assign set = addr_q[AW-1:LINE_W];
  assign tag = addr_q[ADDR_W-1:AW];
  assign req_off = OW'(addr_q) & OMSK;
  assign first_off = CW ? req_off : '0;
  // beat k lands on (first_off + k) mod line size
  assign woff = (first_off + k_q) & OMSK;
  assign fill_a = (addr_q[AW-1:0] & ~AW'((1 << LINE_W) - 1)) | AW'(woff);
  assign hit = valid_q[set] && tag_mem[set] == tag && !inh_q;
  assign rd_hit = state_q == LOOKUP && hit && !we_q;
  assign last = k_q == OMSK;
  // a read hit frees the pipeline in LOOKUP so back-to-back hits run at one per cycle
  assign acc = cache_precycle_enable && (state_q == IDLE || (state_q == DONE && !pend_q) || rd_hit);
  // a request held during a background fill is replayed from DONE, reading the array after the last beat
  assign raddr = (state_q == DONE && pend_q) ? p_addr_q[AW-1:0] : cache_precycle_addr[AW-1:0];

  assign cache_datai = rd_hit ? rdata_q : datai_q;
  assign cache_busy = state_q == RD_REQ || state_q == WR_REQ || (state_q == RD_FILL && (!CW || !cap_q || pend_q)) ||
                      (state_q == DONE && pend_q);
  assign mem_do_act = state_q == RD_REQ || state_q == WR_REQ;
  assign mem_we = state_q == WR_REQ;
  assign mem_addr = (CW || we_q) ? addr_q : (addr_q & ~AMSK);
  assign mem_dataintomem = wdata_q;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    inh_d = inh_q;
    p_addr_d = p_addr_q;
    p_we_d = p_we_q;
    p_wdata_d = p_wdata_q;
    p_inh_d = p_inh_q;
    pend_d = pend_q;
    k_d = k_q;
    cap_d = cap_q;
    datai_d = datai_q;
    valid_d = valid_q;
    arr_we = 1'b0;
    arr_wa = addr_q[AW-1:0];
    arr_wd = wdata_q;
    tag_we = 1'b0;
    if (acc) begin
      addr_d = cache_precycle_addr;
      we_d = cache_precycle_we;
      wdata_d = cache_datao;
      inh_d = cache_inhibit;
    end
    case (state_q)
      IDLE: state_d = acc ? LOOKUP : IDLE;
      LOOKUP: begin
        state_d = we_q ? WR_REQ : !hit ? RD_REQ : acc ? LOOKUP : IDLE;
        arr_we = we_q && hit;
        if (rd_hit) datai_d = rdata_q;
      end
      RD_REQ: begin
        state_d = mem_ack ? RD_FILL : RD_REQ;
        k_d = mem_ack ? '0 : k_q;
        cap_d = mem_ack ? 1'b0 : cap_q;
      end
      RD_FILL: begin
        if (mem_data_vld) begin
          k_d = k_q + OW'(1);
          arr_we = !inh_q;
          arr_wa = fill_a;
          arr_wd = mem_datafrommem;
          if (woff == req_off) begin
            datai_d = mem_datafrommem;
            cap_d = 1'b1;
          end
          if (last) begin
            state_d = DONE;
            tag_we = !inh_q;
            if (!inh_q) valid_d[set] = 1'b1;
          end
        end
        if (CW && cap_q && !pend_q && cache_precycle_enable) begin
          pend_d = 1'b1;
          p_addr_d = cache_precycle_addr;
          p_we_d = cache_precycle_we;
          p_wdata_d = cache_datao;
          p_inh_d = cache_inhibit;
        end
      end
      WR_REQ: state_d = mem_ack ? DONE : WR_REQ;
      DONE: begin
        state_d = (pend_q || acc) ? LOOKUP : IDLE;
        if (pend_q) begin
          addr_d = p_addr_q;
          we_d = p_we_q;
          wdata_d = p_wdata_q;
          inh_d = p_inh_q;
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // flush only lands when the FSM goes idle or starts a lookup, so a fill's valid bit is cleared too
    clr = (cache_flush || flush_pend_q) && (state_d == IDLE || state_d == LOOKUP);
    flush_pend_d = (cache_flush || flush_pend_q) && !clr;
    if (clr) valid_d = '0;
  end

  always_ff @(posedge CPU_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      inh_q <= 1'b0;
      p_addr_q <= '0;
      p_we_q <= 1'b0;
      p_wdata_q <= '0;
      p_inh_q <= 1'b0;
      pend_q <= 1'b0;
      k_q <= '0;
      cap_q <= 1'b0;
      datai_q <= '0;
      valid_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      inh_q <= inh_d;
      p_addr_q <= p_addr_d;
      p_we_q <= p_we_d;
      p_wdata_q <= p_wdata_d;
      p_inh_q <= p_inh_d;
      pend_q <= pend_d;
      k_q <= k_d;
      cap_q <= cap_d;
      datai_q <= datai_d;
      valid_q <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    rdata_q <= data_mem[raddr];
    if (arr_we && !RST) data_mem[arr_wa] <= arr_wd;
    if (tag_we && !RST) tag_mem[set] <= tag;
  end
endmodule

// File: tb/tb_snowball_cache_burst.sv
// tb_snowball_cache_burst: randomized and directed checks of snowball_cache_burst against a line-level model
module tb_snowball_cache_burst;
  localparam int W = 4;
  localparam int NS = 16;
`ifdef SNOWBALL_CACHE_CRITWORD_EN
  localparam bit CW = 1'b1;
`else
  localparam bit CW = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic en, we, inh, flush, mem_ack, mem_vld;
  logic [31:0] addr, datao, mem_rdata;
  logic [31:0] cache_datai, mem_addr, mem_dataintomem;
  logic cache_busy, mem_do_act, mem_we;
  int total = 0, bad = 0;
  bit mv [NS];
  int unsigned mt [NS];
  logic [31:0] memm [int unsigned];
  logic [31:0] cdat [int unsigned];
  int o_flush_beat = -1, o_rst_beat = -1;
  bit o_flush_acc = 0, o_pend = 0;

  always #5 clk = ~clk;

  snowball_cache_burst #(.ADDR_W(32), .DATA_W(32), .IDX_W(4), .LINE_W(2)) dut (
    .CPU_CLK(clk), .RST(rst), .cache_precycle_enable(en), .cache_precycle_addr(addr),
    .cache_precycle_we(we), .cache_datao(datao), .cache_inhibit(inh), .cache_flush(flush),
    .cache_datai(cache_datai), .cache_busy(cache_busy), .mem_do_act(mem_do_act), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dataintomem(mem_dataintomem), .mem_ack(mem_ack),
    .mem_data_vld(mem_vld), .mem_datafrommem(mem_rdata)
  );

  function automatic logic [31:0] mread(input logic [31:0] a);
    return memm.exists(a) ? memm[a] : {16'hAAAA, a[15:0] ^ 16'h0104};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++) mv[i] = 0;
  endtask

  // one CPU access with the bench acting as memory; expectations come from the line model
  task automatic xact(input logic [31:0] a, input bit w, input logic [31:0] d, input bit ih);
    int s, first, kc;
    bit eh, eb;
    logic [31:0] ed, ea, base, a2;
    s = (a / W) % NS;
    base = a - a % W;
    a2 = a ^ 32'd1;
    if (o_flush_acc) clear_model();
    eh = !ih && mv[s] && mt[s] == a / (W * NS);
    ed = eh ? cdat[a] : mread(a);
    @(negedge clk);
    en = 1; addr = a; we = w; datao = d; inh = ih; flush = o_flush_acc;
    @(negedge clk);
    en = 0; flush = 0;
    if (!w && eh) begin
      total++;
      if (cache_datai !== ed || mem_do_act !== 1'b0 || cache_busy !== 1'b0) begin
        bad++;
        $display("FAIL hit a=%h data=%h act=%b busy=%b want data=%h act=0 busy=0", a, cache_datai, mem_do_act, cache_busy, ed);
      end
      return;
    end
    if (w && eh) cdat[a] = d;
    @(negedge clk);
    ea = (w || CW) ? a : base;
    total++;
    if (mem_do_act !== 1'b1 || cache_busy !== 1'b1 || mem_we !== w || mem_addr !== ea) begin
      bad++;
      $display("FAIL req a=%h act=%b busy=%b we=%b addr=%h want act=1 busy=1 we=%b addr=%h", a, mem_do_act, cache_busy, mem_we, mem_addr, w, ea);
    end
    if (w) begin
      total++;
      if (mem_dataintomem !== d) begin
        bad++;
        $display("FAIL wdata a=%h got=%h want=%h", a, mem_dataintomem, d);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    total++;
    if (mem_do_act !== 1'b0) begin
      bad++;
      $display("FAIL act_drop a=%h got=%b want=0", a, mem_do_act);
    end
    if (w) begin
      memm[a] = d;
      total++;
      if (cache_busy !== 1'b0) begin
        bad++;
        $display("FAIL wr_done a=%h busy=%b want=0", a, cache_busy);
      end
      return;
    end
    first = CW ? a % W : 0;
    kc = (a % W - first + W) % W;
    for (int k = 0; k < W; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mem_vld = 1;
      mem_rdata = mread(base + (first + k) % W);
      if (k == o_flush_beat) flush = 1;
      if (k == o_rst_beat) rst = 1;
      if (o_pend && k == 1) begin
        en = 1; addr = a2; we = 0; inh = 0;
      end
      @(negedge clk);
      mem_vld = 0; flush = 0; en = 0;
      if (k == o_rst_beat) begin
        rst = 0;
        total++;
        if (mem_do_act !== 1'b0 || cache_busy !== 1'b0) begin
          bad++;
          $display("FAIL rst_fill a=%h act=%b busy=%b want act=0 busy=0", a, mem_do_act, cache_busy);
        end
        for (int j = k + 1; j < W; j++) begin
          mem_vld = 1;
          mem_rdata = $urandom;
          @(negedge clk);
          mem_vld = 0;
        end
        total++;
        if (mem_do_act !== 1'b0 || cache_busy !== 1'b0) begin
          bad++;
          $display("FAIL late_beats a=%h act=%b busy=%b want act=0 busy=0", a, mem_do_act, cache_busy);
        end
        clear_model();
        return;
      end
      eb = CW ? (o_pend && k >= 1) : (k != W - 1);
      total++;
      if (cache_busy !== eb) begin
        bad++;
        $display("FAIL busy_beat a=%h k=%0d got=%b want=%b", a, k, cache_busy, eb);
      end
      if (k == kc) begin
        total++;
        if (cache_datai !== ed) begin
          bad++;
          $display("FAIL crit_data a=%h k=%0d got=%h want=%h", a, k, cache_datai, ed);
        end
      end
    end
    if (!ih) begin
      mv[s] = 1;
      mt[s] = a / (W * NS);
      for (int i = 0; i < W; i++) cdat[base + i] = mread(base + i);
    end
    if (o_flush_beat >= 0) clear_model();
    total++;
    if (cache_datai !== ed) begin
      bad++;
      $display("FAIL load_data a=%h got=%h want=%h", a, cache_datai, ed);
    end
    if (o_pend) begin
      @(negedge clk);
      total++;
      if (cache_busy !== 1'b0 || cache_datai !== cdat[a2]) begin
        bad++;
        $display("FAIL pend_hit a=%h busy=%b data=%h want busy=0 data=%h", a2, cache_busy, cache_datai, cdat[a2]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; we = 0; inh = 0; flush = 0; addr = 0; datao = 0;
    mem_ack = 0; mem_vld = 0; mem_rdata = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++;
    if (cache_busy !== 1'b0 || mem_do_act !== 1'b0 || mem_we !== 1'b0 || cache_datai !== 32'd0 ||
        mem_addr !== 32'd0 || mem_dataintomem !== 32'd0) begin
      bad++;
      $display("FAIL reset busy=%b act=%b we=%b datai=%h addr=%h wd=%h want all 0", cache_busy, mem_do_act, mem_we, cache_datai, mem_addr, mem_dataintomem);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    clear_model();
  endtask

  task automatic test_miss_hit();
    xact(32'h104, 0, 0, 0);
    xact(32'h105, 0, 0, 0);
  endtask

  task automatic test_critword();
    test_flush_idle();
    xact(32'h107, 0, 0, 0);
    for (int i = 0; i < 3; i++) xact(32'h104 + i, 0, 0, 0);
  endtask

  task automatic test_write_hit();
    xact(32'h105, 1, 32'hDEADBEEF, 0);
    xact(32'h105, 0, 0, 0);
    xact(32'h106, 1, 32'h12345678, 1);
    xact(32'h106, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    xact(32'h104, 0, 0, 0);
    @(negedge clk);
    en = 1; we = 0; inh = 0; addr = 32'h104;
    for (int i = 1; i <= W; i++) begin
      prev = addr;
      @(negedge clk);
      total++;
      if (cache_datai !== cdat[prev] || mem_do_act !== 1'b0 || cache_busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b a=%h data=%h act=%b busy=%b want data=%h act=0 busy=0", prev, cache_datai, mem_do_act, cache_busy, cdat[prev]);
      end
      if (i < W) addr = 32'h104 + i;
      else en = 0;
    end
  endtask

  task automatic test_flush_fill();
    o_flush_beat = 1;
    xact(32'h206, 0, 0, 0);
    o_flush_beat = -1;
    xact(32'h206, 0, 0, 0);
  endtask

  task automatic test_reset_fill();
    o_rst_beat = 1;
    xact(32'h30A, 0, 0, 0);
    o_rst_beat = -1;
    xact(32'h30A, 0, 0, 0);
  endtask

  task automatic test_flush_acc();
    xact(32'h104, 0, 0, 0);
    o_flush_acc = 1;
    xact(32'h104, 0, 0, 0);
    o_flush_acc = 0;
  endtask

  task automatic test_pend();
`ifdef SNOWBALL_CACHE_CRITWORD_EN
    test_flush_idle();
    o_pend = 1;
    xact(32'h109, 0, 0, 0);
    o_pend = 0;
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 250; n++) begin
      a = 32'h100 + ($urandom_range(0, 3) << 6) + $urandom_range(0, 63);
      o_flush_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      o_flush_acc = $urandom_range(0, 19) == 0;
      xact(a, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) == 0);
    end
    o_flush_beat = -1;
    o_flush_acc = 0;
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_critword();
    test_write_hit();
    test_back_to_back();
    test_flush_fill();
    test_reset_fill();
    test_flush_acc();
    test_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
